interval_timer_ctrl: RTL and testbench

- Programmable interval-timer controller that sequences a free-standing up-counter datapath.
- Accepts a period/mode configuration through a valid/ready handshake, then runs, stops and re-arms the counter.
- Raises a one-cycle expire pulse and a sticky interrupt on every terminal count.
- Sits between a register/config master and any logic needing periodic or one-shot event timing.

---
 rtl/timer_pkg.sv | 18 +
 rtl/up_counter_w.sv | 25 ++
 rtl/interval_timer_ctrl.sv | 122 ++++++++++++
 tb/tb_interval_timer_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and defaults for the interval timer controller and its counter.
package timer_pkg;

  // Controller state: IDLE waits for configuration/start, RUN counts ticks.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tmr_state_t;

  // Behaviour on terminal count: return to IDLE, or reload and keep running.
  typedef enum logic {
    ONE_SHOT = 1'b0,
    PERIODIC = 1'b1
  } tmr_mode_t;

  localparam int DEFAULT_W = 4;

endpackage

// File: rtl/up_counter_w.sv
// W-bit up-counter used as the timer datapath. A clear takes priority over
// an enable, so the controller can wrap the count on the same edge that
// would otherwise increment it.
module up_counter_w #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // Clear wins over enable; otherwise advance by one when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer controller.
//
// Configuration handshake: a transfer happens on a rising edge where both
// cfg_valid and cfg_ready are high. cfg_ready is high only in IDLE, so the
// period and mode can never change underneath a running count. The offer
// may be held for any number of cycles; nothing is latched while
// cfg_ready is low.
//
// The counter counts 0..P-1 on cycles where tick_in is high. Reaching P-1
// with a tick wraps to 0, pulses expire for one cycle and sets the sticky
// irq. stop always wins over a coincident terminal count. busy mirrors the
// FSM state (1 = RUN) for external observation.
module interval_timer_ctrl
  import timer_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_period,
  input  logic         cfg_periodic,
  input  logic         start,
  input  logic         stop,
  input  logic         tick_in,
  input  logic         irq_clr,
  output logic         busy,
  output logic [W-1:0] count,
  output logic         expire,
  output logic         irq
);

  tmr_state_t   state;
  tmr_mode_t    mode;
  logic [W-1:0] period;
  logic [W-1:0] last;
  logic         cfg_fire;
  logic         run_entry;
  logic         terminal;
  logic         cnt_clr;
  logic         cnt_en;

  // Terminal value P-1 in W bits; P==0 never reaches RUN, so its wrap is moot.
  assign last = period - {{(W-1){1'b0}}, 1'b1};

  assign cfg_fire = cfg_valid & cfg_ready;

  // Start uses the period already latched, even if a new one lands this edge.
  assign run_entry = (state == IDLE) & start & ~stop & (period != '0);

  // A stop in the same cycle suppresses the terminal count entirely.
  assign terminal = (state == RUN) & tick_in & ~stop & (count == last);

  assign cnt_clr = run_entry | terminal;
  assign cnt_en  = busy & tick_in & ~stop;

  up_counter_w #(
    .W (W)
  ) u_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (count)
  );

  // Controller FSM with registered busy/cfg_ready/expire outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode      <= ONE_SHOT;
      period    <= '0;
      busy      <= 1'b0;
      cfg_ready <= 1'b1;
      expire    <= 1'b0;
    end else begin
      expire <= terminal;
      case (state)
        IDLE: begin
          if (cfg_fire) begin
            period <= cfg_period;
            mode   <= tmr_mode_t'(cfg_periodic);
          end
          if (run_entry) begin
            state     <= RUN;
            busy      <= 1'b1;
            cfg_ready <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
          end else if (terminal && (mode == ONE_SHOT)) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  // Sticky interrupt: a new expiry beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else if (terminal) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Directed bench for interval_timer_ctrl (W=4). Inputs change on the falling
// edge, outputs are checked on the falling edge after each rising edge.
module tb_interval_timer_ctrl;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_period;
  logic         cfg_periodic;
  logic         start;
  logic         stop;
  logic         tick_in;
  logic         irq_clr;
  logic         busy;
  logic [W-1:0] count;
  logic         expire;
  logic         irq;

  int checks   = 0;
  int failures = 0;

  interval_timer_ctrl #(.W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_period   (cfg_period),
    .cfg_periodic (cfg_periodic),
    .start        (start),
    .stop         (stop),
    .tick_in      (tick_in),
    .irq_clr      (irq_clr),
    .busy         (busy),
    .count        (count),
    .expire       (expire),
    .irq          (irq)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Driver: one configuration handshake cycle in IDLE.
  task automatic do_cfg(input logic [W-1:0] p, input logic periodic);
    cfg_valid    = 1'b1;
    cfg_period   = p;
    cfg_periodic = periodic;
    cyc();
    cfg_valid = 1'b0;
    chk("cfg_ready_after_cfg", 16'(cfg_ready), 16'd1);
  endtask

  // Driver: pulse start for one edge with the given tick level.
  task automatic do_start(input logic tk);
    start   = 1'b1;
    tick_in = tk;
    cyc();
    start = 1'b0;
    chk("start_busy", 16'(busy), 16'd1);
    chk("start_count", 16'(count), 16'd0);
  endtask

  logic [W-1:0] exp_cnt [7];
  logic         exp_exp [7];
  logic         tick_pat[7];

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_periodic = 1'b0;
    start = 1'b0; stop = 1'b0; tick_in = 1'b0; irq_clr = 1'b0;
    tick_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_cnt  = '{4'd1, 4'd2, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0};
    exp_exp  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    cyc(); cyc();

    // Reset values
    chk("rst_count", 16'(count), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_expire", 16'(expire), 16'd0);
    chk("rst_irq", 16'(irq), 16'd0);
    chk("rst_cfg_ready", 16'(cfg_ready), 16'd1);
    rst_n = 1'b1;
    cyc();

    // One-shot P=5, tick held high
    do_cfg(4'd5, 1'b0);
    do_start(1'b1);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk("os_count", 16'(count), 16'(i));
      chk("os_no_expire", 16'(expire), 16'd0);
      chk("os_busy", 16'(busy), 16'd1);
    end
    cyc();
    chk("os_expire", 16'(expire), 16'd1);
    chk("os_count_wrap", 16'(count), 16'd0);
    chk("os_busy_low", 16'(busy), 16'd0);
    chk("os_irq", 16'(irq), 16'd1);
    chk("os_cfg_ready", 16'(cfg_ready), 16'd1);
    cyc();
    chk("os_expire_one_cycle", 16'(expire), 16'd0);
    chk("os_count_idle", 16'(count), 16'd0);
    tick_in = 1'b0;

    // irq clear, then clear while already low
    irq_clr = 1'b1;
    cyc();
    chk("irq_clr", 16'(irq), 16'd0);
    cyc();
    chk("irq_clr_idle_low", 16'(irq), 16'd0);
    irq_clr = 1'b0;

    // Periodic P=3 with tick gaps
    do_cfg(4'd3, 1'b1);
    do_start(1'b0);
    for (int i = 0; i < 7; i++) begin
      tick_in = tick_pat[i];
      cyc();
      chk("per_count", 16'(count), 16'(exp_cnt[i]));
      chk("per_expire", 16'(expire), 16'(exp_exp[i]));
      chk("per_busy", 16'(busy), 16'd1);
      if (i >= 3) chk("per_irq_sticky", 16'(irq), 16'd1);
    end

    // Clear irq, then clear coincident with an expiry: set wins
    tick_in = 1'b0; irq_clr = 1'b1;
    cyc();
    chk("per_irq_cleared", 16'(irq), 16'd0);
    chk("per_hold_count", 16'(count), 16'd0);
    irq_clr = 1'b0; tick_in = 1'b1;
    cyc();
    chk("per_c1", 16'(count), 16'd1);
    cyc();
    chk("per_c2", 16'(count), 16'd2);
    irq_clr = 1'b1;
    cyc();
    chk("setclr_expire", 16'(expire), 16'd1);
    chk("setclr_irq", 16'(irq), 16'd1);
    irq_clr = 1'b0; tick_in = 1'b0;

    // Config offer during RUN is refused
    cfg_valid = 1'b1; cfg_period = 4'd7; cfg_periodic = 1'b0;
    cyc();
    chk("run_cfg_ready", 16'(cfg_ready), 16'd0);
    cfg_valid = 1'b0;

    // start while RUN ignored (no restart, count holds)
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("run_start_busy", 16'(busy), 16'd1);
    chk("run_start_count", 16'(count), 16'd0);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("stop_busy", 16'(busy), 16'd0);
    chk("stop_cfg_ready", 16'(cfg_ready), 16'd1);

    // Config kept at P=3 periodic: expire after 3 ticks, still running
    do_start(1'b1);
    cyc(); chk("keep_c1", 16'(count), 16'd1);
    cyc(); chk("keep_c2", 16'(count), 16'd2);
    cyc();
    chk("keep_expire", 16'(expire), 16'd1);
    chk("keep_count", 16'(count), 16'd0);
    chk("keep_busy", 16'(busy), 16'd1);
    stop = 1'b1; tick_in = 1'b0;
    cyc();
    stop = 1'b0;
    chk("keep_stop", 16'(busy), 16'd0);

    // Stop priority over terminal, P=4
    do_cfg(4'd4, 1'b0);
    do_start(1'b1);
    cyc(); cyc(); cyc();
    chk("sp_count3", 16'(count), 16'd3);
    stop = 1'b1;
    cyc();
    stop = 1'b0; tick_in = 1'b0;
    chk("sp_no_expire", 16'(expire), 16'd0);
    chk("sp_count_frozen", 16'(count), 16'd3);
    chk("sp_idle", 16'(busy), 16'd0);
    chk("sp_cfg_ready", 16'(cfg_ready), 16'd1);

    // start and stop together in IDLE: stays IDLE
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    chk("ss_idle", 16'(busy), 16'd0);
    chk("ss_count", 16'(count), 16'd3);

    // Config P=0 and start same edge: start uses old P=4
    cfg_valid = 1'b1; cfg_period = 4'd0; cfg_periodic = 1'b0; start = 1'b1;
    cyc();
    cfg_valid = 1'b0; start = 1'b0;
    chk("same_edge_busy", 16'(busy), 16'd1);
    chk("same_edge_count", 16'(count), 16'd0);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("same_edge_stop", 16'(busy), 16'd0);

    // P=0 now latched: start ignored
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("p0_idle", 16'(busy), 16'd0);
    chk("p0_cfg_ready", 16'(cfg_ready), 16'd1);

    // P=15: count reaches 14 then wraps with expire
    do_cfg(4'd15, 1'b0);
    do_start(1'b1);
    for (int i = 1; i <= 14; i++) begin
      cyc();
      chk("p15_count", 16'(count), 16'(i));
      chk("p15_no_expire", 16'(expire), 16'd0);
    end
    cyc();
    chk("p15_expire", 16'(expire), 16'd1);
    chk("p15_wrap", 16'(count), 16'd0);
    chk("p15_idle", 16'(busy), 16'd0);
    tick_in = 1'b0;

    // P=1 periodic: expire follows every tick
    do_cfg(4'd1, 1'b1);
    do_start(1'b0);
    tick_in = 1'b1; cyc();
    chk("p1_e0", 16'(expire), 16'd1);
    chk("p1_c0", 16'(count), 16'd0);
    tick_in = 1'b0; cyc();
    chk("p1_e1", 16'(expire), 16'd0);
    tick_in = 1'b1; cyc();
    chk("p1_e2", 16'(expire), 16'd1);
    cyc();
    chk("p1_e3", 16'(expire), 16'd1);
    chk("p1_busy", 16'(busy), 16'd1);
    stop = 1'b1; tick_in = 1'b0;
    cyc();
    stop = 1'b0;

    // Reset mid-run: P=5 periodic at count 3, irq currently set
    do_cfg(4'd5, 1'b1);
    do_start(1'b1);
    cyc(); cyc(); cyc();
    chk("mr_count3", 16'(count), 16'd3);
    chk("mr_irq_before", 16'(irq), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_count", 16'(count), 16'd0);
    chk("mr_busy", 16'(busy), 16'd0);
    chk("mr_irq", 16'(irq), 16'd0);
    chk("mr_cfg_ready", 16'(cfg_ready), 16'd1);
    cyc(); cyc();
    chk("mr_no_expire", 16'(expire), 16'd0);
    chk("mr_count_held", 16'(count), 16'd0);
    rst_n = 1'b1; tick_in = 1'b0;
    cyc();
    chk("mr_after_busy", 16'(busy), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
